// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// Module   : nibble_serial_adder_pkg
// Brief    : FSM state encoding, nibble width and counter sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // ceil(log2(n)) with a floor of 1 so a 2-nibble counter still gets a bit
  function automatic int cnt_clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_adder_full_adder.sv
// ============================================================================
// Module   : full_adder
// Brief    : Combinational 4-bit adder with carry-in and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : Nibble-serial WIDTH-bit adder with valid/ready handshakes.
//            Define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             NNIB = WIDTH / NIBBLE_W;
  localparam int             CW   = cnt_clog2(NNIB);
  localparam logic [CW-1:0]  LAST = CW'(NNIB - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 carry_q;
  logic [WIDTH-1:0]     a_sh_q;
  logic [WIDTH-1:0]     b_sh_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     s_q;
  logic                 cout_q;

  logic [NIBBLE_W-1:0]  fa_s;
  logic                 fa_cout;
  logic [WIDTH-1:0]     acc_d;

  full_adder u_fa (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New nibble enters from the top; after the last one acc holds the full sum
  assign acc_d = {fa_s, acc_q[WIDTH-1:NIBBLE_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)     state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> NIBBLE_W;
          b_sh_q  <= b_sh_q >> NIBBLE_W;
          carry_q <= fa_cout;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            s_q    <= acc_d;
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // On the last nibble the adder's bit 3 inputs are the operand sign bits
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST) begin
      ovf_q <= (a_sh_q[NIBBLE_W-1] == b_sh_q[NIBBLE_W-1]) &&
               (fa_s[NIBBLE_W-1] != a_sh_q[NIBBLE_W-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Directed self-checking bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NNIB  = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: "busy for NNIB edges after accept, then hold result"
  bit               m_live = 1'b0;
  bit               m_idle, m_done;
  int               m_wait;
  logic [WIDTH:0]   m_res;
  logic             m_asgn, m_bsgn;
  logic [WIDTH-1:0] m_s;
  logic             m_cout, m_ovf;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_live = 1'b1; m_idle = 1'b1; m_done = 1'b0; m_wait = 0;
      m_s = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_live) begin
      if (m_idle) begin
        if (in_valid) begin
          m_idle = 1'b0;
          m_wait = NNIB;
          m_res  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
          m_asgn = a[WIDTH-1];
          m_bsgn = b[WIDTH-1];
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_done = 1'b1;
          {m_cout, m_s} = m_res;
          m_ovf = (m_asgn == m_bsgn) && (m_res[WIDTH-1] != m_asgn);
        end
      end else if (m_done && out_ready) begin
        m_done = 1'b0;
        m_idle = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model in_ready", in_ready, m_idle);
      chk("model out_valid", out_valid, m_done);
      chk("model s", s, m_s);
      chk("model cout", cout, m_cout);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk("model ovf", ovf, m_ovf);
`endif
    end
  end

  // One transaction; result held for 'hold' cycles with in_valid noise injected
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input int hold,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int t0;
    bit seen;
    @(negedge clk);
    chk("lit in_ready before op", in_ready, 1'b1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      chk("lit out_valid timeout", 1'b0, 1'b1);
      return;
    end
    chk("lit latency", cyc - t0, NNIB);
    for (int h = 0; h < hold; h++) begin
      chk("lit hold out_valid", out_valid, 1'b1);
      chk("lit hold s", s, es);
      chk("lit hold cout", cout, ec);
      a = 16'hAAAA; b = 16'hAAAA; in_valid = (h % 2 == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("lit s", s, es);
    chk("lit cout", cout, ec);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("lit ovf", ovf, eo);
`else
    if (eo === 1'bx) chk("lit ovf unknown", 1'b0, 1'b1);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("lit idle after handshake", in_ready, 1'b1);
    chk("lit s kept in idle", s, es);
  endtask

  logic [WIDTH:0] sb_q[$];
  int             acc_cyc[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit reset in_ready", in_ready, 1'b1);
    chk("lit reset out_valid", out_valid, 1'b0);
    chk("lit reset s", s, 16'h0000);
    chk("lit reset cout", cout, 1'b0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0FFF, 1'b0, 0, 16'h2233, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 0, 16'h0001, 1'b1, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 3, 16'h8000, 1'b0, 1'b1);

    // Reset lands in the second RUN cycle
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit rst-mid in_ready", in_ready, 1'b1);
    chk("lit rst-mid out_valid", out_valid, 1'b0);
    chk("lit rst-mid s", s, 16'h0000);
    run_op(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with in_valid held high and a ready consumer
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (sb_q.size() == 0) chk("sb underflow", 1'b1, 1'b0);
        else begin
          logic [WIDTH:0] e;
          e = sb_q.pop_front();
          chk("sb s", s, e[WIDTH-1:0]);
          chk("sb cout", cout, e[WIDTH]);
        end
      end
      if (k < 30) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        if (in_ready) begin
          sb_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
          acc_cyc.push_back(cyc);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    chk("sb drained", sb_q.size(), 0);
    chk("b2b accepts", acc_cyc.size() >= 4, 1'b1);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b period", acc_cyc[i] - acc_cyc[i-1], NNIB + 2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/sum width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  operands presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  addend A.
REQ-007 SHALL have port: b  input  WIDTH  addend B.
REQ-008 SHALL have port: cin  input  1  carry-in to bit 0.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: s  output  WIDTH  sum, registered.
REQ-012 SHALL have port: cout  output  1  carry out of bit WIDTH-1, registered.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN and DONE.
REQ-014 SHALL assert in_ready only in IDLE; an accept is in_valid & in_ready on a rising clk edge.
REQ-015 On accept, SHALL capture a, b and cin, clear the nibble counter and enter RUN.
REQ-016 In RUN, SHALL add exactly one 4-bit nibble per cycle, least significant nibble first, with the carry registered between nibbles.
REQ-017 SHALL leave RUN after WIDTH/4 cycles; out_valid is first high WIDTH/4 edges after the accept edge (4 cycles when WIDTH=16).
REQ-018 In DONE, SHALL hold out_valid high with s and cout stable until out_ready is sampled high, then return to IDLE.
REQ-019 SHALL keep in_ready low in DONE, so that accepting new operands takes at least one IDLE cycle (throughput ≤ 1 result per WIDTH/4+2 cycles).
REQ-020 SHALL ignore in_valid in RUN and DONE; captured operands are not disturbed.
REQ-021 SHALL ignore out_ready outside DONE.
REQ-022 SHALL compute {cout,s} = a + b + cin modulo 2^(WIDTH+1); this is exact unsigned arithmetic with no saturation.
REQ-023 SHALL change s and cout only at the end of RUN; s holds the last result through IDLE.

Reset
REQ-024 rst high at an edge SHALL force IDLE, in_ready=1, out_valid=0, s=0, cout=0, counter=0 and internal carry=0.
REQ-025 Reset SHALL take priority over every other event, including an accept or handshake in the same cycle.
REQ-026 Reset mid-RUN or in DONE SHALL discard the operation, with no partial result driven.

Configuration
REQ-027 The macro NIBBLE_SERIAL_ADDER_OVF_EN SHALL control a signed-overflow output.
REQ-028 When NIBBLE_SERIAL_ADDER_OVF_EN is defined, the block SHALL add port ovf (output, 1 bit), registered alongside s.
REQ-029 ovf SHALL be 1 when a[MSB]==b[MSB] and s[MSB]!=a[MSB], and 0 after reset.
REQ-030 When NIBBLE_SERIAL_ADDER_OVF_EN is undefined, ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 A shared package/header SHALL hold the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), NIBBLE_W=4 and the counter-width function clog2(WIDTH/4).
REQ-032 The block SHALL instantiate the team's existing combinational 4-bit full_adder exactly once, with ports (a,b,cin,s,cout), as the per-cycle nibble datapath.
REQ-033 Operand A and operand B SHALL be held in right-shift registers; the sum SHALL be assembled by shifting nibbles in from the top.

Verification (WIDTH=16)
REQ-034 a=16'h1234, b=16'h0FFF, cin=0 -> s=16'h2233, cout=0; out_valid first high 4 edges after accept.
REQ-035 a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, cout=1, and the carry ripples through all 4 nibbles.
REQ-036 a=16'h8000, b=16'h8000, cin=1 -> s=16'h0001, cout=1; with the macro defined, ovf=1.
REQ-037 out_ready held low 3 cycles in DONE -> out_valid, s and cout stay stable; in_valid pulses with a=16'hAAAA in that window are ignored.
REQ-038 rst asserted during the 2nd RUN cycle -> next cycle is IDLE, out_valid=0, s=0; a following add of 16'h0001+16'h0001 gives 16'h0002.
REQ-039 Back-to-back: in_valid held high with out_ready=1 -> in_ready pulses once per 6 cycles and each result matches a scoreboard.
